// File: rtl/saa_writer.sv
// SAA1099 register writer: a 4-deep {addr,data} request FIFO feeding a
// ce-paced bus sequencer that issues an address phase then a data phase.
module saa_writer #(
    parameter int WR_LEN     = 2,
    parameter int GAP        = 1,
    parameter int ADDR_CACHE = 1
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       ce,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       cs_n,
    output logic       a0,
    output logic       wr_n,
    output logic [7:0] dout,
    output logic       busy
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP} state_t;

    localparam logic [3:0] STROBE_LAST = 4'(WR_LEN - 1);
    localparam logic [3:0] GAP_LAST    = 4'(GAP - 1);

    // request FIFO
    logic [15:0] fifo_q [4];
    logic [1:0]  wp_q, rp_q;
    logic [2:0]  cnt_q, cnt_d;
    logic        rdy_q;
    logic        push, pop;
    logic [15:0] head;

    // sequencer
    state_t      state_q, state_d;
    logic [3:0]  tick_q, tick_d;
    logic        aph_q, aph_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  caddr_q, caddr_d;
    logic        cvld_q, cvld_d;
    logic        a0_q, a0_d;
    logic [7:0]  dout_q, dout_d;
    logic        cs_n_q, cs_n_d;
    logic        wr_n_q, wr_n_d;
    logic        hit;

    assign push  = req_valid & rdy_q;
    assign head  = fifo_q[rp_q];
    assign cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
    assign hit   = (ADDR_CACHE != 0) && cvld_q && (head[15:8] == caddr_q);

    always_ff @(posedge clk_sys) begin
        if (push) fifo_q[wp_q] <= {req_addr, req_data};
    end

    // ready is registered from the post-update count, so a pop frees a slot
    // for the following cycle and reset holds it low for one edge
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            wp_q  <= 2'd0;
            rp_q  <= 2'd0;
            cnt_q <= 3'd0;
            rdy_q <= 1'b0;
        end else begin
            if (push) wp_q <= wp_q + 2'd1;
            if (pop)  rp_q <= rp_q + 2'd1;
            cnt_q <= cnt_d;
            rdy_q <= (cnt_d != 3'd4);
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        aph_d   = aph_q;
        wdata_d = wdata_q;
        caddr_d = caddr_q;
        cvld_d  = cvld_q;
        a0_d    = a0_q;
        dout_d  = dout_q;
        pop     = 1'b0;
        if (ce) begin
            case (state_q)
                S_IDLE: begin
                    if (cnt_q != 3'd0) begin
                        pop     = 1'b1;
                        wdata_d = head[7:0];
                        state_d = S_SETUP;
                        if (hit) begin
                            aph_d  = 1'b0;
                            a0_d   = 1'b0;
                            dout_d = head[7:0];
                        end else begin
                            aph_d  = 1'b1;
                            a0_d   = 1'b1;
                            dout_d = head[15:8];
                        end
                    end
                end
                S_SETUP: begin
                    tick_d  = 4'd0;
                    state_d = S_STROBE;
                end
                S_STROBE: begin
                    if (tick_q == STROBE_LAST) state_d = S_HOLD;
                    else                       tick_d  = tick_q + 4'd1;
                end
                S_HOLD: begin
                    tick_d  = 4'd0;
                    state_d = S_GAP;
                    // dout still carries the register number during an address phase
                    if (aph_q) begin
                        caddr_d = dout_q;
                        cvld_d  = 1'b1;
                    end
                end
                S_GAP: begin
                    if (tick_q != GAP_LAST) begin
                        tick_d = tick_q + 4'd1;
                    end else if (aph_q) begin
                        aph_d   = 1'b0;
                        a0_d    = 1'b0;
                        dout_d  = wdata_q;
                        state_d = S_SETUP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        cs_n_d = !(state_d == S_SETUP || state_d == S_STROBE || state_d == S_HOLD);
        wr_n_d = (state_d != S_STROBE);
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q <= S_IDLE;
            tick_q  <= 4'd0;
            aph_q   <= 1'b0;
            wdata_q <= 8'h00;
            caddr_q <= 8'h00;
            cvld_q  <= 1'b0;
            a0_q    <= 1'b0;
            dout_q  <= 8'h00;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            aph_q   <= aph_d;
            wdata_q <= wdata_d;
            caddr_q <= caddr_d;
            cvld_q  <= cvld_d;
            a0_q    <= a0_d;
            dout_q  <= dout_d;
            cs_n_q  <= cs_n_d;
            wr_n_q  <= wr_n_d;
        end
    end

    assign req_ready = rdy_q;
    assign cs_n      = cs_n_q;
    assign wr_n      = wr_n_q;
    assign a0        = a0_q;
    assign dout      = dout_q;
    assign busy      = (cnt_q != 3'd0) || (state_q != S_IDLE);
endmodule

// File: tb/tb_saa_writer.sv
// Bench for saa_writer: two instances (defaults; WR_LEN=3/GAP=2/no cache) share
// stimulus; a bus monitor records writes and a request-level model predicts them.
module tb_saa_writer;
    logic       clk_sys = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_data = 8'h00;
    logic [1:0] rdy_w, cs_n_w, a0_w, wr_n_w, busy_w;
    logic [7:0] dout_w [2];

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        saa_writer #(
            .WR_LEN    (g == 0 ? 2 : 3),
            .GAP       (g == 0 ? 1 : 2),
            .ADDR_CACHE(g == 0 ? 1 : 0)
        ) u_dut (
            .clk_sys  (clk_sys),
            .rst      (rst),
            .ce       (ce),
            .req_valid(req_valid),
            .req_ready(rdy_w[g]),
            .req_addr (req_addr),
            .req_data (req_data),
            .cs_n     (cs_n_w[g]),
            .a0       (a0_w[g]),
            .wr_n     (wr_n_w[g]),
            .dout     (dout_w[g]),
            .busy     (busy_w[g])
        );
    end

    function automatic int wrl(input int g);
        return (g == 0) ? 2 : 3;
    endfunction
    function automatic int gapl(input int g);
        return (g == 0) ? 1 : 2;
    endfunction
    function automatic bit cache_en(input int g);
        return (g == 0);
    endfunction

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got 0x%0h expected 0x%0h", name, g, act, exp);
        end
    endtask

    // bus monitor, sampled on the falling edge
    logic [8:0] cap    [2][512];
    int         caplen [2][512];
    int         ncap   [2];
    int         lowrun [2];
    int         hirun  [2];
    int         agap   [2];
    logic       pcs [2], pwr [2], pa0 [2];
    logic [7:0] pdo [2];

    initial begin
        for (int g = 0; g < 2; g++) begin
            ncap[g] = 0; lowrun[g] = 0; hirun[g] = 0; agap[g] = 0;
            pcs[g] = 1'b1; pwr[g] = 1'b1; pa0[g] = 1'b0; pdo[g] = 8'h00;
        end
    end

    always @(negedge clk_sys) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                pcs[g] = 1'b1; pwr[g] = 1'b1; lowrun[g] = 0; hirun[g] = 0;
            end else begin
                if (!wr_n_w[g]) chk("wr_outside_cs", g, cs_n_w[g], 0);
                if (!cs_n_w[g] && !pcs[g])
                    chk("bus_stable_in_cs", g, {a0_w[g], dout_w[g]}, {pa0[g], pdo[g]});
                if (!wr_n_w[g]) begin
                    lowrun[g]++;
                end else if (!pwr[g]) begin
                    if (ncap[g] < 512) begin
                        cap[g][ncap[g]]    = {pa0[g], pdo[g]};
                        caplen[g][ncap[g]] = lowrun[g];
                        ncap[g]++;
                    end
                    lowrun[g] = 0;
                end
                if (cs_n_w[g]) hirun[g] = pcs[g] ? hirun[g] + 1 : 1;
                else if (pcs[g] && ncap[g] > 0 && cap[g][ncap[g]-1][8]) agap[g] = hirun[g];
                pcs[g] = cs_n_w[g]; pwr[g] = wr_n_w[g]; pa0[g] = a0_w[g]; pdo[g] = dout_w[g];
            end
        end
    end

    // request-level reference model
    typedef struct packed { logic [7:0] a; logic [7:0] d; } req_t;
    req_t       pend [$];
    bit         cvld  [2];
    logic [7:0] caddr [2];
    int         base  [2];
    int         ce_mode = 0;  // 0 manual, 1 one-in-three, 2 random
    int         ce_ph = 0;
    int         ce_div = 1;   // clk cycles per ce tick, 0 when irregular

    task automatic step();
        @(posedge clk_sys);
        #1;
        case (ce_mode)
            1: begin ce_ph = (ce_ph + 1) % 3; ce = (ce_ph == 0); end
            2: ce = 1'($urandom_range(0, 1));
            default: ;
        endcase
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] d);
        int n = 0;
        while (rdy_w != 2'b11 && n < 2000) begin step(); n++; end
        chk("push_wait", 0, {31'd0, rdy_w == 2'b11}, 1);
        req_addr = a; req_data = d; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        pend.push_back({a, d});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_w != 2'b00 && n < 3000) begin step(); n++; end
        chk("idle_wait", 0, {30'd0, busy_w}, 0);
        step();
    endtask

    task automatic check_writes(input string name);
        for (int g = 0; g < 2; g++) begin
            logic [8:0] ex [$];
            ex = {};
            foreach (pend[i]) begin
                if (!(cache_en(g) && cvld[g] && caddr[g] == pend[i].a)) ex.push_back({1'b1, pend[i].a});
                ex.push_back({1'b0, pend[i].d});
                cvld[g] = 1'b1; caddr[g] = pend[i].a;
            end
            chk($sformatf("%s_count", name), g, ncap[g] - base[g], ex.size());
            for (int i = 0; i < ex.size() && base[g] + i < ncap[g]; i++) begin
                chk($sformatf("%s_wr%0d", name, i), g, {23'd0, cap[g][base[g]+i]}, {23'd0, ex[i]});
                if (ce_div > 0)
                    chk($sformatf("%s_len%0d", name, i), g, caplen[g][base[g]+i], wrl(g) * ce_div);
            end
            base[g] = ncap[g];
        end
        pend = {};
    endtask

    typedef struct { logic [7:0] a; logic [7:0] d; int nwr0; int nwr1; } vec_t;
    vec_t tbl [6];

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t [2];
        int n;
        tbl[0] = '{8'h1C, 8'h01, 2, 2};
        tbl[1] = '{8'h1C, 8'h05, 1, 2};
        tbl[2] = '{8'h00, 8'h20, 2, 2};
        tbl[3] = '{8'h00, 8'h15, 1, 2};
        tbl[4] = '{8'h1C, 8'h07, 2, 2};
        tbl[5] = '{8'h1C, 8'hFF, 1, 2};
        for (int g = 0; g < 2; g++) begin cvld[g] = 1'b0; caddr[g] = 8'h00; base[g] = 0; end

        // reset values
        rst = 1'b1; ce = 1'b1;
        repeat (3) step();
        for (int g = 0; g < 2; g++) begin
            chk("rst_cs_n", g, cs_n_w[g], 1);
            chk("rst_wr_n", g, wr_n_w[g], 1);
            chk("rst_a0", g, a0_w[g], 0);
            chk("rst_dout", g, dout_w[g], 0);
            chk("rst_ready", g, rdy_w[g], 0);
            chk("rst_busy", g, busy_w[g], 0);
        end
        rst = 1'b0;
        step();
        for (int g = 0; g < 2; g++) chk("ready_after_rst", g, rdy_w[g], 1);

        // single requests, ce every cycle: bus-cycle count sets busy duration
        foreach (tbl[v]) begin
            push(tbl[v].a, tbl[v].d);
            for (int g = 0; g < 2; g++) begin chk("busy_on_push", g, busy_w[g], 1); t[g] = 0; end
            for (int k = 1; k <= 100 && (t[0] == 0 || t[1] == 0); k++) begin
                step();
                for (int g = 0; g < 2; g++) if (t[g] == 0 && !busy_w[g]) t[g] = k;
            end
            chk("busy_span", 0, t[0], 1 + tbl[v].nwr0 * (2 + wrl(0) + gapl(0)));
            chk("busy_span", 1, t[1], 1 + tbl[v].nwr1 * (2 + wrl(1) + gapl(1)));
            step();
            check_writes($sformatf("tbl%0d", v));
        end

        // back-to-back requests to one register
        push(8'h00, 8'h20);
        push(8'h00, 8'h15);
        wait_idle();
        check_writes("same_addr");

        // ce stuck low: fill FIFO, then release
        ce = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < 2; g++) chk("fill_ready", g, rdy_w[g], 1);
            req_addr = 8'(i + 1); req_data = 8'(8'h11 * (i + 1)); req_valid = 1'b1;
            step();
            pend.push_back({req_addr, req_data});
        end
        req_addr = 8'h05; req_data = 8'h55;
        for (int r = 0; r < 3; r++) begin
            for (int g = 0; g < 2; g++) begin
                chk("full_ready", g, rdy_w[g], 0);
                chk("frozen_cs_n", g, cs_n_w[g], 1);
            end
            if (r < 2) step();
        end
        ce = 1'b1;
        step();
        for (int g = 0; g < 2; g++) chk("ready_after_pop", g, rdy_w[g], 1);
        step();
        req_valid = 1'b0;
        pend.push_back({8'h05, 8'h55});
        wait_idle();
        check_writes("fifo_full");

        // ce one clock in three
        ce_mode = 1; ce_div = 3;
        push(8'h41, 8'hAA);
        wait_idle();
        check_writes("slow_ce");
        for (int g = 0; g < 2; g++) chk("addr_data_gap", g, agap[g], gapl(g) * 3);
        ce_mode = 0; ce = 1'b1; ce_div = 1;

        // reset during data-phase strobe
        push(8'h30, 8'h99);
        n = 0;
        while (!(wr_n_w[0] == 1'b0 && a0_w[0] == 1'b0) && n < 200) begin step(); n++; end
        chk("reach_data_strobe", 0, {31'd0, n < 200}, 1);
        rst = 1'b1;
        step();
        for (int g = 0; g < 2; g++) begin
            chk("midrst_wr_n", g, wr_n_w[g], 1);
            chk("midrst_cs_n", g, cs_n_w[g], 1);
            chk("midrst_busy", g, busy_w[g], 0);
        end
        rst = 1'b0;
        pend = {};
        for (int g = 0; g < 2; g++) begin cvld[g] = 1'b0; base[g] = ncap[g]; end
        repeat (20) step();
        for (int g = 0; g < 2; g++) chk("no_pulse_after_rst", g, ncap[g] - base[g], 0);
        push(8'h30, 8'h5A);
        wait_idle();
        check_writes("after_rst");

        // random requests with random ce against the model
        ce_mode = 2; ce_div = 0;
        for (int it = 0; it < 25; it++) begin
            int np = $urandom_range(1, 6);
            for (int p = 0; p < np; p++) begin
                push(8'($urandom_range(0, 3)), 8'($urandom));
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 8)) step();
            end
            wait_idle();
            check_writes($sformatf("rnd%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
